// File: rtl/kernel_wavetable_reader_pkg.sv
// Shared types, constants and address helper for the wavetable reader.
package kernel_wavetable_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ABORT = 2'd3
  } state_e;

  localparam int MEM_WORDS  = 5120;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LAT     = 1;

  // base + idx folded back into the memory once; idx never exceeds one window.
  function automatic int unsigned wrap_addr(input int unsigned base,
                                            input int unsigned idx,
                                            input int unsigned mem_words);
    int unsigned sum;
    sum = base + idx;
    if (sum >= mem_words) sum = sum - mem_words;
    return sum;
  endfunction

endpackage

// File: rtl/kernel_wavetable_reader_if.sv
// Avalon-MM read port plus sample stream bundled into one interface.
interface kernel_wavetable_reader_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_clken;
  logic [DATA_W-1:0] avm_readdata;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;

  modport master (
    output avm_address, avm_chipselect, avm_write, avm_byteenable,
    output avm_writedata, avm_clken, st_data, st_valid,
    input  avm_readdata, st_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write, avm_byteenable,
    input  avm_writedata, avm_clken, st_data, st_valid,
    output avm_readdata, st_ready
  );
endinterface

// File: rtl/kernel_wavetable_fifo.sv
// First-word-fall-through FIFO; the head entry is always visible on rdata_o.
module kernel_wavetable_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [DATA_W-1:0]      wdata_i,
  output logic [DATA_W-1:0]      rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage, pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
endmodule

// File: rtl/kernel_wavetable_reader.sv
// Streams a window of on-chip memory words into the DDS sample path.
//
//   state | meaning
//   IDLE  | waiting for start; nothing outstanding
//   RUN   | issuing reads while FIFO credit allows
//   DRAIN | all reads of a one-shot pass issued; emptying FIFO
//   ABORT | stop seen; waiting for the last read, then flush
module kernel_wavetable_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int MEM_WORDS  = kernel_wavetable_pkg::MEM_WORDS,
  parameter int FIFO_DEPTH = kernel_wavetable_pkg::FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [ADDR_W-1:0]          length,
  input  logic                       loop_en,
  output logic                       busy,
  output logic                       done,
  kernel_wavetable_reader_if.master  bus
);
  import kernel_wavetable_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q, len_q, idx_q, addr_q;
  logic              loop_q, cs_q, busy_q, done_q;
  logic [RD_LAT-1:0] rd_pipe_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full, fifo_push, fifo_pop, fifo_flush;
  logic [DATA_W-1:0] fifo_head;

  logic              st_valid_w, can_issue, pass_end, rd_idle;
  int                count_nxt;
  logic [ADDR_W-1:0] issue_base, issue_idx, issue_len, issue_addr, idx_inc;

  // Credit, next-read address and pass-end decode shared by the FSM.
  always_comb begin
    st_valid_w = !fifo_empty && (state_q != ABORT);
    fifo_pop   = st_valid_w && bus.st_ready;
    fifo_push  = rd_pipe_q[RD_LAT-1];
    rd_idle    = !cs_q && (rd_pipe_q == '0);
    fifo_flush = (state_q == ABORT) && rd_idle;
    // Occupancy after this edge plus the read still on the bus must leave room.
    count_nxt  = int'(fifo_count) + int'(fifo_push) - int'(fifo_pop);
    can_issue  = !fifo_full && ((count_nxt + int'(cs_q)) < FIFO_DEPTH);
    // In IDLE the first read goes out on the start edge itself.
    issue_base = (state_q == IDLE) ? base_addr : base_q;
    issue_idx  = (state_q == IDLE) ? '0 : idx_q;
    issue_len  = (state_q == IDLE) ? length : len_q;
    issue_addr = ADDR_W'(wrap_addr(32'(issue_base), 32'(issue_idx), MEM_WORDS));
    idx_inc    = issue_idx + 1'b1;
    pass_end   = (idx_inc == issue_len);
  end

  // Sequencer with registered Avalon strobe, busy and done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      loop_q    <= 1'b0;
      cs_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_pipe_q <= '0;
    end else begin
      done_q    <= 1'b0;
      cs_q      <= 1'b0;
      rd_pipe_q <= RD_LAT'({rd_pipe_q, cs_q});
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            if (length == '0) begin
              done_q <= 1'b1;
            end else begin
              base_q <= base_addr;
              len_q  <= length;
              loop_q <= loop_en;
              cs_q   <= 1'b1;
              addr_q <= issue_addr;
              busy_q <= 1'b1;
              if (pass_end) begin
                idx_q   <= '0;
                state_q <= loop_en ? RUN : DRAIN;
              end else begin
                idx_q   <= idx_inc;
                state_q <= RUN;
              end
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= ABORT;
          end else if (can_issue) begin
            cs_q   <= 1'b1;
            addr_q <= issue_addr;
            if (pass_end) begin
              idx_q <= '0;
              if (!loop_q) state_q <= DRAIN;
            end else begin
              idx_q <= idx_inc;
            end
          end
        end
        DRAIN: begin
          if (stop) begin
            state_q <= ABORT;
          end else if (rd_idle && (count_nxt == 0)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ABORT: begin
          if (rd_idle) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  kernel_wavetable_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (bus.avm_readdata),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign bus.avm_address    = addr_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_write      = 1'b0;
  assign bus.avm_byteenable = 4'hF;
  assign bus.avm_writedata  = '0;
  assign bus.avm_clken      = 1'b1;
  assign bus.st_data        = fifo_head;
  assign bus.st_valid       = st_valid_w;
  assign busy               = busy_q;
  assign done               = done_q;
endmodule

// File: doc/kernel_wavetable_reader.md
# kernel_wavetable_reader

Avalon-MM read master that streams a contiguous window of 32-bit waveform words out of the NIOS-side on-chip memory (5120 × 32, single-port, 1-cycle read latency) into the DDS sample path. It sits between the on-chip memory's slave port and the DDS phase/sample pipeline. It supports one-shot or looping playback, and uses a small credit-controlled FIFO so that downstream backpressure never drops a returned read.

## Interface
Parameters:
- ADDR_W, 13, word address width of the memory slave
- DATA_W, 32, data width
- MEM_WORDS, 5120, memory depth in words; address arithmetic wraps modulo this value
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- stop  in  1  abort request; honoured in any state
- base_addr  in  ADDR_W  first word address, latched on start
- length  in  ADDR_W  number of words per pass, latched on start
- loop_en  in  1  1 = replay the window indefinitely, latched on start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at end of a one-shot pass or after an abort completes
- avm_address  out  ADDR_W  memory word address
- avm_chipselect  out  1  read strobe (write is held low, so a chipselect is a read)
- avm_write  out  1  constant 0
- avm_byteenable  out  4  constant 4'hF
- avm_writedata  out  DATA_W  constant 0
- avm_clken  out  1  constant 1
- avm_readdata  in  DATA_W  valid exactly one cycle after the chipselect cycle
- st_data  out  DATA_W  sample word (FIFO head)
- st_valid  out  1  FIFO not empty
- st_ready  in  1  downstream accept; transfer occurs when st_valid & st_ready

## Operation
- States: IDLE, RUN, DRAIN, ABORT.
- IDLE: on start with length ≠ 0, latch base_addr, length and loop_en, clear idx, and go to RUN. On start with length = 0, pulse done the next cycle and stay in IDLE.
- RUN: issue a read when fifo_count + inflight < FIFO_DEPTH. Inflight is 0 or 1.
  - Read address is base + idx; subtract MEM_WORDS when the sum is ≥ MEM_WORDS.
  - After each issue, idx increments.
  - When idx reaches length: if loop_en, idx returns to 0 and the state stays RUN; otherwise go to DRAIN.
- Read return: the cycle after each chipselect, avm_readdata is pushed into the FIFO. A push is never refused, because the credit rule guarantees space.
- DRAIN: no new reads. When inflight = 0 and the FIFO is empty, pulse done and go to IDLE.
- stop (any non-IDLE state): stop issuing reads and go to ABORT. ABORT waits for inflight = 0, then flushes the FIFO in one cycle, pulses done and goes to IDLE. st_valid is forced low from the cycle after stop is sampled.
- If start and stop are both sampled in IDLE, stop wins: nothing is latched and done is not pulsed.
- A push and a pop in the same cycle leave fifo_count unchanged.

## Timing
- Reset values: state = IDLE; avm_address = 0; avm_chipselect = 0; busy = 0; done = 0; st_valid = 0; st_data = 0; FIFO empty; inflight = 0.
- Latency: start is sampled at cycle T. At T+1, avm_chipselect = 1 with avm_address = base. Data is captured at the end of T+2. st_valid = 1 at T+3.
- Throughput: with st_ready held high, one read issues and one word transfers every cycle once the pipeline has filled.
- Backpressure: with st_ready low, exactly FIFO_DEPTH reads complete and no further chipselect is issued until a pop occurs.
- All outputs are registered. done is high for exactly one cycle.

## Structure
- Package kernel_wavetable_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, ABORT);
  - the constants MEM_WORDS, FIFO_DEPTH and the read latency (RD_LAT = 1);
  - the address wrap function.
- One sub-module, kernel_wavetable_fifo: a synchronous FIFO (DATA_W × FIFO_DEPTH) with push, pop, flush, count, empty and full. It is first-word-fall-through, so its head drives st_data.
- The top level contains the FSM, the idx counter, the inflight flag and the Avalon drive logic.

## Test plan
- One-shot: base = 10, length = 3, st_ready = 1 → reads to addresses 10, 11, 12 on consecutive cycles; st_data = mem[10..12] in order; done pulses once; busy falls in the same cycle as done.
- Wrap: base = 5118, length = 4 → addresses 5118, 5119, 0, 1.
- Loop with backpressure: base = 0, length = 2, loop_en = 1, st_ready = 0 for 20 cycles → exactly 4 chipselects are issued, then none until st_ready rises. The subsequent output sequence is mem[0], mem[1], mem[0], mem[1], … with no gaps or duplicates.
- Abort: stop asserted mid-RUN with the FIFO holding 3 words → the in-flight read completes, the FIFO is flushed, st_valid drops, done pulses once, and the block is back in IDLE within 3 cycles.
- Edge inputs:
  - length = 0 → no chipselect is issued and done pulses at T+1.
  - start while busy → ignored.
- Reset mid-RUN: reset_n driven low asynchronously → all outputs return to their reset values immediately. After release, start behaves normally.
